// File: rtl/bus_master_port_if.sv
// Command-side and shared-bus signals of one bus master port.
// The master modport is the port itself; slave is the environment side.
interface bus_master_port_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  bus_req;
    logic                  bus_grant;
    logic                  bus_valid;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_data;
    logic                  bus_ready;
    logic                  busy;
    logic [LVL_W-1:0]      fifo_level;
    logic                  starve_err;
    logic                  starve_clr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_data, bus_grant, bus_ready, starve_clr,
        output cmd_ready, bus_req, bus_valid, bus_addr, bus_data, busy, fifo_level, starve_err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_data, bus_grant, bus_ready, starve_clr,
        input  cmd_ready, bus_req, bus_valid, bus_addr, bus_data, busy, fifo_level, starve_err
    );
endinterface

// File: rtl/bus_master_port.sv
// Master endpoint of the request/grant shared bus: queues write commands,
// requests the bus, drives bounded bursts while granted and flags starvation.
module bus_master_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    bus_master_port_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int BCW   = $clog2(MAX_BURST + 1);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [BCW-1:0]   BEAT_MAX = BCW'(MAX_BURST);
    localparam logic [15:0]      WAIT_MAX = 16'(TIMEOUT);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_RELEASE
    } state_t;

    cmd_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    state_t           r_state;
    logic             r_bus_req;
    logic [BCW-1:0]   r_beat_cnt;
    logic [15:0]      r_wait_cnt;
    logic             r_starve_err;

    state_t           w_next_state;
    logic [LVL_W-1:0] w_level_next;
    logic             w_fifo_empty;
    logic             w_cmd_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_bus_valid;
    logic             w_burst_cap;
    logic             w_last_pop;
    logic             w_starve_hit;
    logic [BCW-1:0]   w_beat_inc;
    cmd_t             w_head;

    assign w_fifo_empty = (r_level == '0);
    assign w_cmd_ready  = (r_level < LVL_FULL);
    assign w_push       = bus.cmd_valid && w_cmd_ready;
    assign w_bus_valid  = r_bus_req && bus.bus_grant && !w_fifo_empty;
    assign w_pop        = w_bus_valid && bus.bus_ready;
    assign w_head       = r_mem[r_rd_ptr];

    always_comb begin
        w_level_next = r_level;
        unique case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LVL_W'(1);
            2'b01:   w_level_next = r_level - LVL_W'(1);
            default: w_level_next = r_level;
        endcase
    end

    // A tenure ends on the beat that hits the burst cap or leaves the FIFO empty.
    assign w_beat_inc  = r_beat_cnt + BCW'(1);
    assign w_burst_cap = w_pop && (w_beat_inc == BEAT_MAX);
    assign w_last_pop  = w_pop && (w_level_next == '0);

    // NOTE: storage array has no reset; emptiness lives in the pointers and
    // level, so a reset flushes the queue without clearing the RAM itself.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_t'({bus.cmd_addr, bus.cmd_data});
        end
    end

    // NOTE: all state updates use non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_next;
        end
    end

    // NOTE: next-state is defaulted before the case so no path holds a
    // previous value, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ, S_XFER: begin
                if (w_pop) begin
                    w_next_state = (w_burst_cap || w_last_pop) ? S_RELEASE : S_XFER;
                end
            end
            S_RELEASE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_bus_req  <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_bus_req <= (w_next_state == S_REQ) || (w_next_state == S_XFER);
            if (r_state == S_IDLE && w_next_state == S_REQ) begin
                r_beat_cnt <= '0;
            end else if (w_pop) begin
                r_beat_cnt <= w_beat_inc;
            end
        end
    end

    // Starvation: count ungranted request cycles, saturating at the limit.
    assign w_starve_hit = r_bus_req && !bus.bus_grant && (r_wait_cnt == WAIT_MAX - 16'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt   <= '0;
            r_starve_err <= 1'b0;
        end else begin
            if (!r_bus_req || bus.bus_grant) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_starve_hit) begin
                r_starve_err <= 1'b1;
            end else if (bus.starve_clr) begin
                r_starve_err <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.bus_req    = r_bus_req;
    assign bus.bus_valid  = w_bus_valid;
    assign bus.bus_addr   = w_head.addr;
    assign bus.bus_data   = w_head.data;
    assign bus.busy       = !w_fifo_empty || (r_state != S_IDLE);
    assign bus.fifo_level = r_level;
    assign bus.starve_err = r_starve_err;
endmodule

// File: tb/tb_bus_master_port.sv
// Scenario bench for bus_master_port: directed protocol cases plus a random
// run checked against a queue model of the command stream.
module tb_bus_master_port;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int MAXB  = 4;
    localparam int TMO   = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_pass  = 0;
    int   n_total = 0;

    bus_master_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) bif ();

    bus_master_port #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
        .MAX_BURST(MAXB), .TIMEOUT(TMO)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bif.cmd_valid  = 1'b0;
        bif.cmd_addr   = '0;
        bif.cmd_data   = '0;
        bif.bus_grant  = 1'b0;
        bif.bus_ready  = 1'b0;
        bif.starve_clr = 1'b0;
    endtask

    task automatic clear_starve();
        bif.starve_clr = 1'b1;
        cyc();
        bif.starve_clr = 1'b0;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.a = AW'($urandom);
        c.d = $urandom;
        return c;
    endfunction

    task automatic test_reset();
        cmd_t c;
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (bif.bus_req !== 1'b0) $display("FAIL rst_bus_req: got %b want 0", bif.bus_req); else n_pass++;
        n_total++; if (bif.bus_valid !== 1'b0) $display("FAIL rst_bus_valid: got %b want 0", bif.bus_valid); else n_pass++;
        n_total++; if (bif.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", bif.cmd_ready); else n_pass++;
        n_total++; if (bif.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bif.busy); else n_pass++;
        n_total++; if (bif.fifo_level !== '0) $display("FAIL rst_level: got %0d want 0", bif.fifo_level); else n_pass++;
        n_total++; if (bif.starve_err !== 1'b0) $display("FAIL rst_starve: got %b want 0", bif.starve_err); else n_pass++;
        reset_n = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            c = rand_cmd();
            bif.cmd_valid = 1'b1;
            bif.cmd_addr  = c.a;
            bif.cmd_data  = c.d;
            cyc();
        end
        bif.cmd_valid = 1'b0;
        bif.bus_grant = 1'b1;
        bif.bus_ready = 1'b1;
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        n_total++; if (bif.bus_req !== 1'b0) $display("FAIL midrst_bus_req: got %b want 0", bif.bus_req); else n_pass++;
        n_total++; if (bif.bus_valid !== 1'b0) $display("FAIL midrst_bus_valid: got %b want 0", bif.bus_valid); else n_pass++;
        n_total++; if (bif.fifo_level !== '0) $display("FAIL midrst_level: got %0d want 0", bif.fifo_level); else n_pass++;
        n_total++; if (bif.cmd_ready !== 1'b1) $display("FAIL midrst_cmd_ready: got %b want 1", bif.cmd_ready); else n_pass++;
        n_total++; if (bif.starve_err !== 1'b0) $display("FAIL midrst_starve: got %b want 0", bif.starve_err); else n_pass++;
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_total++; if (bif.bus_valid !== 1'b0 || bif.bus_req !== 1'b0)
                $display("FAIL postrst_stale_beat: got valid=%b req=%b want 0/0", bif.bus_valid, bif.bus_req); else n_pass++;
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_single();
        bif.cmd_valid = 1'b1;
        bif.cmd_addr  = 16'h0010;
        bif.cmd_data  = 32'hDEADBEEF;
        cyc();
        bif.cmd_valid = 1'b0;
        settle();
        n_total++; if (bif.fifo_level !== 3'd1) $display("FAIL single_level: got %0d want 1", bif.fifo_level); else n_pass++;
        n_total++; if (bif.bus_req !== 1'b0) $display("FAIL single_req_early: got %b want 0", bif.bus_req); else n_pass++;
        cyc();
        n_total++; if (bif.bus_req !== 1'b1) $display("FAIL single_req: got %b want 1", bif.bus_req); else n_pass++;
        n_total++; if (bif.bus_valid !== 1'b0) $display("FAIL single_valid_nogrant: got %b want 0", bif.bus_valid); else n_pass++;
        cyc();
        cyc();
        bif.bus_grant = 1'b1;
        bif.bus_ready = 1'b1;
        settle();
        n_total++; if (bif.bus_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bif.bus_valid); else n_pass++;
        n_total++; if (bif.bus_addr !== 16'h0010 || bif.bus_data !== 32'hDEADBEEF)
            $display("FAIL single_beat: got %h/%h want 0010/deadbeef", bif.bus_addr, bif.bus_data); else n_pass++;
        cyc();
        n_total++; if (bif.bus_req !== 1'b0 || bif.bus_valid !== 1'b0)
            $display("FAIL single_release: got req=%b valid=%b want 0/0", bif.bus_req, bif.bus_valid); else n_pass++;
        cyc();
        n_total++; if (bif.busy !== 1'b0 || bif.bus_req !== 1'b0)
            $display("FAIL single_idle: got busy=%b req=%b want 0/0", bif.busy, bif.bus_req); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_burst_cap();
        cmd_t sent [6];
        cmd_t got [$];
        int   beat_cyc [$];
        bit   req_tr [$];
        int   pi;
        bit   acc;
        for (int i = 0; i < 6; i++) sent[i] = rand_cmd();
        pi = 0;
        bif.bus_grant = 1'b1;
        bif.bus_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bif.cmd_valid = (pi < 6);
            if (pi < 6) begin
                bif.cmd_addr = sent[pi].a;
                bif.cmd_data = sent[pi].d;
            end
            settle();
            acc = bif.cmd_valid && bif.cmd_ready;
            req_tr.push_back(bif.bus_req);
            if (bif.bus_valid && bif.bus_ready) begin
                got.push_back(cmd_t'({bif.bus_addr, bif.bus_data}));
                beat_cyc.push_back(c);
            end
            cyc();
            if (acc) pi++;
        end
        idle_inputs();
        n_total++; if (pi != 6) $display("FAIL burst_accepted: got %0d want 6", pi); else n_pass++;
        n_total++; if (got.size() != 6) $display("FAIL burst_beats: got %0d want 6", got.size()); else n_pass++;
        if (got.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                n_total++; if (got[i] !== sent[i]) $display("FAIL burst_order[%0d]: got %h want %h", i, got[i], sent[i]); else n_pass++;
            end
            n_total++; if (beat_cyc[3] - beat_cyc[0] != 3) $display("FAIL burst_contig: got span %0d want 3", beat_cyc[3] - beat_cyc[0]); else n_pass++;
            n_total++; if (beat_cyc[4] - beat_cyc[3] != 3) $display("FAIL burst_gap: got %0d want 3", beat_cyc[4] - beat_cyc[3]); else n_pass++;
            n_total++; if (req_tr[beat_cyc[3]+1] !== 1'b0 || req_tr[beat_cyc[3]+2] !== 1'b0 || req_tr[beat_cyc[3]+3] !== 1'b1)
                $display("FAIL burst_req_gap: got %b%b%b want 001", req_tr[beat_cyc[3]+1], req_tr[beat_cyc[3]+2], req_tr[beat_cyc[3]+3]); else n_pass++;
            n_total++; if (beat_cyc[5] - beat_cyc[4] != 1) $display("FAIL burst_tail: got %0d want 1", beat_cyc[5] - beat_cyc[4]); else n_pass++;
        end
        settle();
        n_total++; if (bif.busy !== 1'b0) $display("FAIL burst_busy: got %b want 0", bif.busy); else n_pass++;
    endtask

    task automatic test_full_fifo();
        cmd_t sent [5];
        cmd_t got [$];
        int   pi;
        bit   acc;
        for (int i = 0; i < 5; i++) sent[i] = rand_cmd();
        pi = 0;
        bif.bus_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            bif.cmd_valid = 1'b1;
            bif.cmd_addr  = sent[pi].a;
            bif.cmd_data  = sent[pi].d;
            settle();
            acc = bif.cmd_ready;
            cyc();
            if (acc) pi++;
        end
        settle();
        n_total++; if (pi != 4) $display("FAIL full_accepted: got %0d want 4", pi); else n_pass++;
        n_total++; if (bif.fifo_level !== 3'd4) $display("FAIL full_level: got %0d want 4", bif.fifo_level); else n_pass++;
        n_total++; if (bif.cmd_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", bif.cmd_ready); else n_pass++;
        bif.bus_grant = 1'b1;
        settle();
        n_total++; if (bif.bus_valid !== 1'b1 || bif.cmd_ready !== 1'b0)
            $display("FAIL full_pop_cycle: got valid=%b ready=%b want 1/0", bif.bus_valid, bif.cmd_ready); else n_pass++;
        got.push_back(cmd_t'({bif.bus_addr, bif.bus_data}));
        cyc();
        bif.bus_grant = 1'b0;
        settle();
        n_total++; if (bif.fifo_level !== 3'd3 || bif.cmd_ready !== 1'b1)
            $display("FAIL full_after_pop: got level=%0d ready=%b want 3/1", bif.fifo_level, bif.cmd_ready); else n_pass++;
        cyc();
        bif.cmd_valid = 1'b0;
        settle();
        n_total++; if (bif.fifo_level !== 3'd4) $display("FAIL full_fifth: got %0d want 4", bif.fifo_level); else n_pass++;
        bif.bus_grant = 1'b1;
        for (int c = 0; c < 40 && bif.busy; c++) begin
            settle();
            if (bif.bus_valid && bif.bus_ready) got.push_back(cmd_t'({bif.bus_addr, bif.bus_data}));
            cyc();
        end
        n_total++; if (bif.busy !== 1'b0) $display("FAIL full_drain_timeout: got busy=%b want 0", bif.busy); else n_pass++;
        n_total++; if (got.size() != 5) $display("FAIL full_beats: got %0d want 5", got.size()); else n_pass++;
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_total++; if (got[i] !== sent[i]) $display("FAIL full_order[%0d]: got %h want %h", i, got[i], sent[i]); else n_pass++;
        end
        idle_inputs();
        clear_starve();
    endtask

    task automatic test_grant_loss();
        cmd_t sent [4];
        for (int i = 0; i < 4; i++) begin
            sent[i] = rand_cmd();
            bif.cmd_valid = 1'b1;
            bif.cmd_addr  = sent[i].a;
            bif.cmd_data  = sent[i].d;
            cyc();
        end
        bif.cmd_valid = 1'b0;
        bif.bus_grant = 1'b1;
        bif.bus_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                bif.bus_grant = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    settle();
                    n_total++; if (bif.bus_valid !== 1'b0 || bif.bus_req !== 1'b1)
                        $display("FAIL gloss_hold[%0d]: got valid=%b req=%b want 0/1", k, bif.bus_valid, bif.bus_req); else n_pass++;
                    cyc();
                end
                bif.bus_grant = 1'b1;
            end
            settle();
            n_total++; if (bif.bus_valid !== 1'b1 || {bif.bus_addr, bif.bus_data} !== sent[b])
                $display("FAIL gloss_beat[%0d]: got v=%b %h%h want 1 %h", b, bif.bus_valid, bif.bus_addr, bif.bus_data, sent[b]); else n_pass++;
            cyc();
        end
        settle();
        n_total++; if (bif.bus_req !== 1'b0 || bif.fifo_level !== '0)
            $display("FAIL gloss_release: got req=%b level=%0d want 0/0", bif.bus_req, bif.fifo_level); else n_pass++;
        idle_inputs();
        cyc();
        cyc();
    endtask

    task automatic test_starvation();
        cmd_t c;
        clear_starve();
        n_total++; if (bif.starve_err !== 1'b0) $display("FAIL starve_pre: got %b want 0", bif.starve_err); else n_pass++;
        c = rand_cmd();
        bif.cmd_valid = 1'b1;
        bif.cmd_addr  = c.a;
        bif.cmd_data  = c.d;
        cyc();
        bif.cmd_valid = 1'b0;
        cyc();
        for (int k = 1; k <= TMO; k++) begin
            cyc();
            if (k == TMO - 1) begin
                n_total++; if (bif.starve_err !== 1'b0) $display("FAIL starve_early: got %b want 0", bif.starve_err); else n_pass++;
            end
            if (k == TMO) begin
                n_total++; if (bif.starve_err !== 1'b1) $display("FAIL starve_set: got %b want 1", bif.starve_err); else n_pass++;
            end
        end
        bif.bus_grant = 1'b1;
        bif.bus_ready = 1'b1;
        settle();
        n_total++; if (bif.bus_valid !== 1'b1) $display("FAIL starve_no_flush: got %b want 1", bif.bus_valid); else n_pass++;
        cyc();
        cyc();
        n_total++; if (bif.starve_err !== 1'b1) $display("FAIL starve_sticky: got %b want 1", bif.starve_err); else n_pass++;
        idle_inputs();
        clear_starve();
        n_total++; if (bif.starve_err !== 1'b0) $display("FAIL starve_clr: got %b want 0", bif.starve_err); else n_pass++;
        cyc();
        c = rand_cmd();
        bif.cmd_valid = 1'b1;
        bif.cmd_addr  = c.a;
        bif.cmd_data  = c.d;
        cyc();
        bif.cmd_valid = 1'b0;
        cyc();
        for (int k = 1; k <= TMO; k++) begin
            if (k == TMO) bif.starve_clr = 1'b1;
            cyc();
            bif.starve_clr = 1'b0;
        end
        n_total++; if (bif.starve_err !== 1'b1) $display("FAIL starve_set_wins: got %b want 1", bif.starve_err); else n_pass++;
        clear_starve();
        n_total++; if (bif.starve_err !== 1'b0) $display("FAIL starve_clr2: got %b want 0", bif.starve_err); else n_pass++;
        bif.bus_grant = 1'b1;
        bif.bus_ready = 1'b1;
        cyc();
        cyc();
        idle_inputs();
        cyc();
        n_total++; if (bif.fifo_level !== '0 || bif.busy !== 1'b0)
            $display("FAIL starve_drain: got level=%0d busy=%b want 0/0", bif.fifo_level, bif.busy); else n_pass++;
    endtask

    // Random traffic against a queue of accepted commands; bus rules are
    // checked as protocol invariants rather than cycle-exact state.
    task automatic test_random();
        cmd_t q [$];
        cmd_t c;
        int   tenure_beats = 0;
        int   low_run = 2;
        bit   exp_rel = 1'b0;
        bit   exp_ready;
        bit   beat;
        for (int cy = 0; cy < 3000; cy++) begin
            c = rand_cmd();
            bif.cmd_valid  = ($urandom_range(0, 1) == 1);
            bif.cmd_addr   = c.a;
            bif.cmd_data   = c.d;
            bif.bus_grant  = ($urandom_range(0, 3) != 0);
            bif.bus_ready  = ($urandom_range(0, 3) != 0);
            bif.starve_clr = ($urandom_range(0, 1) == 1);
            settle();
            exp_ready = (q.size() < DEPTH);
            n_total++; if (int'(bif.fifo_level) != q.size()) $display("FAIL rnd_level@%0d: got %0d want %0d", cy, bif.fifo_level, q.size()); else n_pass++;
            n_total++; if (bif.cmd_ready !== exp_ready) $display("FAIL rnd_ready@%0d: got %b want %b", cy, bif.cmd_ready, exp_ready); else n_pass++;
            n_total++; if (bif.bus_valid !== (bif.bus_req && bif.bus_grant && q.size() != 0))
                $display("FAIL rnd_valid@%0d: got %b want %b", cy, bif.bus_valid, bif.bus_req && bif.bus_grant && q.size() != 0); else n_pass++;
            if (bif.bus_req) begin
                n_total++; if (q.size() == 0) $display("FAIL rnd_req_empty@%0d: got req=1 want 0", cy); else n_pass++;
            end
            if (exp_rel) begin
                n_total++; if (bif.bus_req !== 1'b0) $display("FAIL rnd_release@%0d: got req=%b want 0", cy, bif.bus_req); else n_pass++;
            end
            if (bif.bus_req && low_run > 0) begin
                n_total++; if (low_run < 2) $display("FAIL rnd_gap@%0d: got %0d want >=2", cy, low_run); else n_pass++;
            end
            beat = bif.bus_valid && bif.bus_ready;
            if (beat && q.size() != 0) begin
                n_total++; if ({bif.bus_addr, bif.bus_data} !== q[0])
                    $display("FAIL rnd_beat@%0d: got %h%h want %h", cy, bif.bus_addr, bif.bus_data, q[0]); else n_pass++;
            end
            if (bif.bus_req) begin
                low_run = 0;
                if (beat) tenure_beats++;
            end else begin
                low_run++;
                tenure_beats = 0;
            end
            if (beat) begin
                n_total++; if (tenure_beats > MAXB) $display("FAIL rnd_cap@%0d: got %0d want <=%0d", cy, tenure_beats, MAXB); else n_pass++;
            end
            cyc();
            if (beat && q.size() != 0) void'(q.pop_front());
            if (bif.cmd_valid && exp_ready) q.push_back(c);
            exp_rel = beat && (tenure_beats == MAXB || q.size() == 0);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_cap();
        test_full_fifo();
        test_grant_loss();
        test_starvation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
